// File: rtl/bidir_shift_pkg.sv
// Shared definitions for the bi-directional shift register family (PISO transmitter, SIPO receiver).
package bidir_shift_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/bidir_piso_shift_tx_piso_bit_counter.sv
// Bit-position counter for the PISO transmitter; flags the final bit of a word.
module piso_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_is_last
);

  logic [CNT_W-1:0] r_cnt;

  // Clear wins over increment so a reload on the last bit restarts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_is_last = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/bidir_piso_shift_tx.sv
// Parallel-in serial-out transmitter; direction chosen per word, back-to-back words without gaps.
module bidir_piso_shift_tx
  import bidir_shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  input  logic [WIDTH-1:0] i_d_par,
  input  logic             i_right,
  input  logic             i_en,
  output logic             o_s_out,
  output logic             o_s_valid,
  output logic             o_s_last
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_nextState;
  logic [WIDTH-1:0]   r_shreg;
  logic               r_dir;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_cntLast;
  logic               w_shifting;
  logic               w_accept;
  logic               w_endWord;

  assign w_shifting   = (r_state == ST_SHIFT);
  assign o_s_valid    = w_shifting;
  assign o_s_last     = w_shifting && w_cntLast;
  assign o_load_ready = (r_state == ST_IDLE) || (o_s_last && i_en);
  assign o_s_out      = r_dir ? r_shreg[0] : r_shreg[WIDTH-1];
  assign w_accept     = i_load_valid && o_load_ready;
  assign w_endWord    = o_s_last && i_en;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bitCounter (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_accept || w_endWord),
    .i_inc     (w_shifting && i_en),
    .o_cnt     (w_cnt),
    .o_is_last (w_cntLast)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_load_valid) begin
          w_nextState = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_endWord && !i_load_valid) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Zeroing the register at the end of a word keeps s_out low while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg <= '0;
      r_dir   <= DIR_LEFT;
    end else if (w_accept) begin
      r_shreg <= i_d_par;
      r_dir   <= i_right;
    end else if (w_shifting && i_en) begin
      if (w_cntLast) begin
        r_shreg <= '0;
      end else if (r_dir == DIR_RIGHT) begin
        r_shreg <= r_shreg >> 1;
      end else begin
        r_shreg <= r_shreg << 1;
      end
    end
  end

endmodule

// File: tb/tb_bidir_piso_shift_tx.sv
// Scoreboard bench for bidir_piso_shift_tx: stimulus queues expected bits, a negedge monitor checks them.
module tb_bidir_piso_shift_tx;
  import bidir_shift_pkg::*;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             loadValid;
  logic             loadReady;
  logic [WIDTH-1:0] dPar;
  logic             right;
  logic             en;
  logic             sOut;
  logic             sValid;
  logic             sLast;

  typedef struct {
    logic b;
    logic last;
  } bit_exp_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } chk_t;

  bit_exp_t expQ[$];
  chk_t     chkQ[$];
  int       total = 0;
  int       bad   = 0;

  bidir_piso_shift_tx #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_load_valid (loadValid),
    .o_load_ready (loadReady),
    .i_d_par      (dPar),
    .i_right      (right),
    .i_en         (en),
    .o_s_out      (sOut),
    .o_s_valid    (sValid),
    .o_s_last     (sLast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: settles queued point checks, then consumes one expected bit per enabled valid cycle.
  always @(negedge clk) begin
    chk_t     c;
    bit_exp_t e;
    while (chkQ.size() > 0) begin
      c = chkQ.pop_front();
      total++;
      if (c.act != c.exp) begin
        bad++;
        $display("[TB] FAIL %s: got %0d expected %0d", c.name, c.act, c.exp);
      end
    end
    if (!rst && sValid && en) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_bit: got s_out=%0b with no word pending, expected none", sOut);
      end else begin
        e = expQ.pop_front();
        if (sOut !== e.b || sLast !== e.last) begin
          bad++;
          $display("[TB] FAIL serial_bit: got s_out=%0b s_last=%0b expected s_out=%0b s_last=%0b",
                   sOut, sLast, e.b, e.last);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chkQ.push_back(c);
  endtask

  // Queues the hand-computed bit order (MSB of expBits goes out first) and waits for the accept.
  task automatic applyStimulus(input logic [WIDTH-1:0] word, input logic dir,
                               input logic [WIDTH-1:0] expBits, output logic lastAtAccept);
    bit_exp_t e;
    logic     accepted;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      e.b    = expBits[i];
      e.last = (i == 0);
      expQ.push_back(e);
    end
    dPar         = word;
    right        = dir;
    loadValid    = 1'b1;
    accepted     = 1'b0;
    lastAtAccept = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (loadReady) begin
        accepted     = 1'b1;
        lastAtAccept = sLast;
        break;
      end
    end
    if (!accepted) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    loadValid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    logic idle;
    idle = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!sValid) begin
        idle = 1'b1;
        break;
      end
    end
    checkOutput(name, int'(idle), 1);
    checkOutput({name, "_ready"}, int'(loadReady), 1);
    checkOutput({name, "_sout"}, int'(sOut), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic lastAcc;
    rst       = 1'b1;
    loadValid = 1'b0;
    dPar      = '0;
    right     = 1'b0;
    en        = 1'b1;
    #12;
    checkOutput("reset_s_out", int'(sOut), 0);
    checkOutput("reset_s_valid", int'(sValid), 0);
    checkOutput("reset_s_last", int'(sLast), 0);
    checkOutput("reset_load_ready", int'(loadReady), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] MSB-first word 1011");
    applyStimulus(4'b1011, DIR_LEFT, 4'b1011, lastAcc);
    waitIdle("msb_idle");

    $display("[TB] LSB-first word 1011");
    applyStimulus(4'b1011, DIR_RIGHT, 4'b1101, lastAcc);
    waitIdle("lsb_idle");

    $display("[TB] back-to-back 1100 then 0011");
    applyStimulus(4'b1100, DIR_LEFT, 4'b1100, lastAcc);
    applyStimulus(4'b0011, DIR_LEFT, 4'b0011, lastAcc);
    checkOutput("b2b_accept_on_last", int'(lastAcc), 1);
    waitIdle("b2b_idle");

    $display("[TB] stall during second bit of 1001");
    applyStimulus(4'b1001, DIR_LEFT, 4'b1001, lastAcc);
    @(posedge clk);
    #1;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_s_out", int'(sOut), 0);
      checkOutput("stall_s_valid", int'(sValid), 1);
      checkOutput("stall_load_ready", int'(loadReady), 0);
      @(posedge clk);
      #1;
    end
    en = 1'b1;
    waitIdle("stall_idle");

    $display("[TB] busy rejection of 1111");
    applyStimulus(4'b1011, DIR_LEFT, 4'b1011, lastAcc);
    @(posedge clk);
    #1;
    loadValid = 1'b1;
    dPar      = 4'b1111;
    right     = DIR_RIGHT;
    @(negedge clk);
    checkOutput("busy_load_ready", int'(loadReady), 0);
    @(posedge clk);
    #1;
    loadValid = 1'b0;
    right     = DIR_LEFT;
    waitIdle("busy_idle");
    checkOutput("busy_pending_bits", expQ.size(), 0);

    $display("[TB] async reset during third bit of 1110");
    applyStimulus(4'b1110, DIR_LEFT, 4'b1110, lastAcc);
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    checkOutput("pre_reset_s_out", int'(sOut), 1);
    rst = 1'b1;
    #1;
    checkOutput("async_s_out", int'(sOut), 0);
    checkOutput("async_s_valid", int'(sValid), 0);
    checkOutput("async_s_last", int'(sLast), 0);
    checkOutput("async_load_ready", int'(loadReady), 1);
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(4'b0110, DIR_RIGHT, 4'b0110, lastAcc);
    waitIdle("post_reset_idle");

    checkOutput("final_pending_bits", expQ.size(), 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
